// File: rtl/ir_pkg.sv
// ============================================================================
// Module  : ir_pkg
// Purpose : Shared types and constants for the NEC infrared transmitter.
//           Holds the transmitter state enum, the NEC unit counts for each
//           frame element and the default clk27 cycle constants.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ir_pkg;

  // Transmitter states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5,
    ST_GAP        = 3'd6
  } ir_state_t;

  // NEC element lengths, in 562.5 us units
  localparam logic [7:0] c_lead_mark_units   = 8'd16;
  localparam logic [7:0] c_data_space_units  = 8'd8;
  localparam logic [7:0] c_rpt_space_units   = 8'd4;
  localparam logic [7:0] c_bit_units         = 8'd1;
  localparam logic [7:0] c_one_space_units   = 8'd3;
  localparam int         c_frame_units_def   = 192;

  // Default clk27 cycle constants
  localparam int c_unit_cycles_def   = 15188;
  localparam int c_carrier_div_def   = 711;
  localparam int c_carrier_high_def  = 237;

  // Length of a fixed-duration state in units. GAP and IDLE return 0:
  // GAP is terminated by the frame counter, IDLE by start.
  function automatic logic [7:0] state_units(input ir_state_t st,
                                             input logic      is_repeat,
                                             input logic      bit_val);
    logic [7:0] units;
    units = 8'd0;
    case (st)
      ST_LEAD_MARK:  units = c_lead_mark_units;
      ST_LEAD_SPACE: units = is_repeat ? c_rpt_space_units : c_data_space_units;
      ST_BIT_MARK:   units = c_bit_units;
      ST_BIT_SPACE:  units = bit_val ? c_one_space_units : c_bit_units;
      ST_STOP_MARK:  units = c_bit_units;
      default:       units = 8'd0;
    endcase
    return units;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ir_tx_carrier.sv
// ============================================================================
// Module  : ir_tx_carrier
// Purpose : IR carrier phase generator. A phase counter runs over
//           0..CARRIER_DIV-1; the carrier is high for the first CARRIER_HIGH
//           phases. A restart forces the coming cycle to phase 0 so every
//           mark begins with a full high carrier phase.
// Ports   : clk27       in   system clock
//           reset_n     in   synchronous active-low reset
//           restart     in   force phase 0 for the next cycle
//           carrier_nxt out  carrier level for the next cycle (feeds a
//                            register in the parent)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_tx_carrier
  import ir_pkg::*;
#(
  parameter int CARRIER_DIV  = c_carrier_div_def,
  parameter int CARRIER_HIGH = c_carrier_high_def
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic restart,
  output logic carrier_nxt
);

  localparam int c_phase_w = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [c_phase_w-1:0] c_phase_last = c_phase_w'(CARRIER_DIV - 1);
  localparam logic [c_phase_w-1:0] c_phase_high = c_phase_w'(CARRIER_HIGH);

  logic [c_phase_w-1:0] r_phase;
  logic [c_phase_w-1:0] w_phase_nxt;

  always_comb begin
    w_phase_nxt = '0;
    if (!restart && (r_phase != c_phase_last)) begin
      w_phase_nxt = r_phase + 1'b1;
    end
    carrier_nxt = (w_phase_nxt < c_phase_high);
  end

  always_ff @(posedge clk27) begin
    if (!reset_n) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ir_tx.sv
// ============================================================================
// Module  : ir_tx
// Purpose : NEC-protocol infrared transmitter. Encodes a 16-bit address/
//           command code into a full NEC frame (leader, 32 data bits,
//           stop mark, gap to 108 ms) and optionally follows it with NEC
//           repeat frames while repeat_hold is high.
// Config  : IR_TX_CARRIER_EN defined   -> ir_led = mark AND 38 kHz carrier,
//                                         active-high, idles at 0.
//           IR_TX_CARRIER_EN undefined -> ir_led = ~mark, active-low
//                                         envelope, idles at 1; carrier
//                                         logic is not built.
// Ports   : clk27       in   27 MHz system clock
//           reset_n     in   synchronous active-low reset
//           start       in   one-cycle request, accepted only while idle
//           code        in   [15:8] address, [7:0] command
//           repeat_hold in   request repeat frames after the current frame
//           busy        out  frame(s) in progress
//           done        out  one-cycle pulse on return to idle
//           ir_led      out  LED drive
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_tx
  import ir_pkg::*;
#(
  parameter int UNIT_CYCLES  = c_unit_cycles_def,
  parameter int FRAME_UNITS  = c_frame_units_def,
  parameter int CARRIER_DIV  = c_carrier_div_def,
  parameter int CARRIER_HIGH = c_carrier_high_def
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] code,
  input  logic        repeat_hold,
  output logic        busy,
  output logic        done,
  output logic        ir_led
);

  localparam int c_presc_w = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(UNIT_CYCLES - 1);
  localparam logic [7:0] c_frame_units = 8'(FRAME_UNITS);
  localparam logic [4:0] c_last_bit    = 5'd31;

  ir_state_t            r_state;
  ir_state_t            w_state_nxt;
  logic [c_presc_w-1:0] r_presc;
  logic [7:0]           r_dur;
  logic [7:0]           r_frame;
  logic [31:0]          r_shift;
  logic [4:0]           r_bitcnt;
  logic                 r_repeat;
  logic                 r_mark;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_led;

  logic                 w_unit_tick;
  logic                 w_state_end;
  logic                 w_frame_end;
  logic                 w_mark_nxt;
  logic                 w_led_nxt;
  logic [7:0]           w_dur_inc;
  logic [7:0]           w_frame_inc;
  logic [7:0]           w_state_units;

  // Next-state decode. The registered outputs are computed from the next
  // state so that mark/busy/ir_led change on the same edge as the state.
  always_comb begin
    w_unit_tick   = (r_presc == c_presc_last);
    w_dur_inc     = r_dur + 8'd1;
    w_frame_inc   = r_frame + 8'd1;
    w_state_units = state_units(r_state, r_repeat, r_shift[0]);
    w_state_end   = w_unit_tick && (w_dur_inc == w_state_units);
    w_frame_end   = (r_state == ST_GAP) && w_unit_tick && (w_frame_inc == c_frame_units);
    w_state_nxt   = r_state;
    case (r_state)
      ST_IDLE:       if (start)       w_state_nxt = ST_LEAD_MARK;
      ST_LEAD_MARK:  if (w_state_end) w_state_nxt = ST_LEAD_SPACE;
      ST_LEAD_SPACE: if (w_state_end) w_state_nxt = r_repeat ? ST_STOP_MARK : ST_BIT_MARK;
      ST_BIT_MARK:   if (w_state_end) w_state_nxt = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (w_state_end) w_state_nxt = (r_bitcnt == c_last_bit) ? ST_STOP_MARK
                                                                              : ST_BIT_MARK;
      ST_STOP_MARK:  if (w_state_end) w_state_nxt = ST_GAP;
      ST_GAP:        if (w_frame_end) w_state_nxt = repeat_hold ? ST_LEAD_MARK : ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
    w_mark_nxt = (w_state_nxt == ST_LEAD_MARK) ||
                 (w_state_nxt == ST_BIT_MARK)  ||
                 (w_state_nxt == ST_STOP_MARK);
  end

`ifdef IR_TX_CARRIER_EN
  localparam logic c_led_idle = 1'b0;
  logic w_carrier_nxt;

  // Phase restarts on every space-to-mark transition
  ir_tx_carrier #(
    .CARRIER_DIV  (CARRIER_DIV),
    .CARRIER_HIGH (CARRIER_HIGH)
  ) u_carrier (
    .clk27       (clk27),
    .reset_n     (reset_n),
    .restart     (w_mark_nxt & ~r_mark),
    .carrier_nxt (w_carrier_nxt)
  );

  assign w_led_nxt = w_mark_nxt & w_carrier_nxt;
`else
  localparam logic c_led_idle = 1'b1;
  logic w_unused_carrier;

  // Carrier parameters have no function in envelope mode
  assign w_unused_carrier = ^{32'(CARRIER_DIV), 32'(CARRIER_HIGH)};
  assign w_led_nxt        = ~w_mark_nxt;
`endif

  always_ff @(posedge clk27) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_presc  <= '0;
      r_dur    <= '0;
      r_frame  <= '0;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_repeat <= 1'b0;
      r_mark   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_led    <= c_led_idle;
    end else begin
      r_state <= w_state_nxt;
      r_mark  <= w_mark_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_frame_end && !repeat_hold;

      if (r_state == ST_IDLE) begin
        r_presc <= '0;
        r_dur   <= '0;
        r_frame <= '0;
        if (start) begin
          // Sent LSB first: addr, ~addr, cmd, ~cmd
          r_shift  <= {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
          r_bitcnt <= '0;
          r_repeat <= 1'b0;
        end
      end else begin
        r_presc <= w_unit_tick ? '0 : r_presc + 1'b1;
        if (w_frame_end) begin
          // Frame counter restarts with the next leader (repeat frame)
          r_frame  <= '0;
          r_dur    <= '0;
          r_repeat <= repeat_hold;
        end else if (w_unit_tick) begin
          r_frame <= w_frame_inc;
          r_dur   <= w_state_end ? 8'd0 : w_dur_inc;
          if ((r_state == ST_BIT_SPACE) && w_state_end) begin
            r_shift  <= r_shift >> 1;
            r_bitcnt <= r_bitcnt + 5'd1;
          end
        end
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign ir_led = r_led;

endmodule

`default_nettype wire

// File: tb/tb_ir_tx.sv
// ============================================================================
// Module  : tb_ir_tx
// Purpose : Directed self-checking bench for ir_tx with UNIT_CYCLES=10,
//           CARRIER_DIV=6, CARRIER_HIGH=2. Works in both IR_TX_CARRIER_EN
//           builds; expected LED levels come from a small frame model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ir_tx;

  localparam int U = 10;

  logic        clk27;
  logic        reset_n;
  logic        start;
  logic [15:0] code;
  logic        repeat_hold;
  logic        busy;
  logic        done;
  logic        ir_led;

  int checks;
  int failures;

  logic cap      [0:3999];
  logic bz       [0:3999];
  logic dn       [0:3999];
  logic exp_mark [0:3999];

  ir_tx #(
    .UNIT_CYCLES  (U),
    .FRAME_UNITS  (192),
    .CARRIER_DIV  (6),
    .CARRIER_HIGH (2)
  ) dut (
    .clk27       (clk27),
    .reset_n     (reset_n),
    .start       (start),
    .code        (code),
    .repeat_hold (repeat_hold),
    .busy        (busy),
    .done        (done),
    .ir_led      (ir_led)
  );

  initial clk27 = 1'b0;
  always #5 clk27 = ~clk27;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // LED level for a mark/space cycle; ph = cycles since the mark began
  function automatic logic led_of(input logic m, input int ph);
`ifdef IR_TX_CARRIER_EN
    return m && ((ph % 6) < 2);
`else
    return !m;
`endif
  endfunction

  task automatic add_seg(inout int idx, input logic m, input int units);
    for (int i = 0; i < units * U; i++) begin
      exp_mark[idx] = m;
      idx++;
    end
  endtask

  // Frame 0 is a data frame, later frames are repeat frames
  task automatic build_model(input logic [15:0] c, input int nframes);
    logic [31:0] p;
    int idx;
    p   = {~c[7:0], c[7:0], ~c[15:8], c[15:8]};
    idx = 0;
    for (int f = 0; f < nframes; f++) begin
      add_seg(idx, 1'b1, 16);
      add_seg(idx, 1'b0, (f == 0) ? 8 : 4);
      if (f == 0) begin
        for (int b = 0; b < 32; b++) begin
          add_seg(idx, 1'b1, 1);
          add_seg(idx, 1'b0, p[b] ? 3 : 1);
        end
      end
      add_seg(idx, 1'b1, 1);
      add_seg(idx, 1'b0, (f + 1) * 192 - idx / U);
    end
  endtask

  task automatic compare_wave(input string tag, input int len);
    int   mism;
    int   ms;
    logic e;
    mism = 0;
    ms   = 0;
    for (int i = 0; i < len; i++) begin
      if (exp_mark[i] && ((i == 0) || !exp_mark[i-1])) ms = i;
      e = led_of(exp_mark[i], i - ms);
      if (cap[i] !== e) mism++;
    end
    check(tag, mism, 0);
  endtask

  // Sample n cycles starting just after the start edge; optional ignored
  // start, repeat_hold release and one-cycle reset at given sample indices.
  task automatic capture(input int n, input int ign_at, input int rel_at, input int rst_at);
    for (int k = 0; k < n; k++) begin
      cap[k] = ir_led;
      bz[k]  = busy;
      dn[k]  = done;
      start  = 1'b0;
      if (k == ign_at) begin
        start = 1'b1;
        code  = 16'h1234;
      end
      if (k == rel_at) repeat_hold = 1'b0;
      reset_n = (k == rst_at) ? 1'b0 : 1'b1;
      @(posedge clk27); #1;
    end
    start   = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic kick(input logic [15:0] c);
    start = 1'b1;
    code  = c;
    @(posedge clk27); #1;
    start = 1'b0;
  endtask

  function automatic int first_done(input int n);
    for (int k = 0; k < n; k++) if (dn[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int count_done(input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) if (dn[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_busy(input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) if (bz[k] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    logic [11:0] pat;
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    start       = 1'b1;
    code        = 16'h20DF;
    repeat_hold = 1'b0;

    // Reset with start held high
    repeat (5) @(posedge clk27);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_led", ir_led, led_of(1'b0, 0));
    reset_n = 1'b1;
    start   = 1'b0;
    @(posedge clk27); #1;
    check("rst_no_start", busy, 1'b0);
    repeat (3) @(posedge clk27);
    #1;

    // Data frame 0x20DF with an ignored start at sample 500
    kick(16'h20DF);
    capture(1922, 500, -1, -1);
    check("data_lead_first", cap[0], led_of(1'b1, 0));
    check("data_lead_last", cap[159], led_of(1'b1, 159));
    check("data_lspace_first", cap[160], led_of(1'b0, 0));
    check("data_bit0_mark", cap[240], led_of(1'b1, 0));
    check("data_bit0_space", cap[250], led_of(1'b0, 0));
    check("data_bit1_mark", cap[260], led_of(1'b1, 0));
    check("data_bit5_mark", cap[345], led_of(1'b1, 5));
    check("data_bit5_space", cap[375], led_of(1'b0, 0));
    check("data_bit6_mark", cap[380], led_of(1'b1, 0));
    check("data_stop_mark", cap[1205], led_of(1'b1, 5));
    check("data_gap", cap[1210], led_of(1'b0, 0));
    check("data_idle_led", cap[1920], led_of(1'b0, 0));
`ifdef IR_TX_CARRIER_EN
    for (int i = 0; i < 12; i++) pat[11-i] = cap[i];
    check("carrier_pattern", pat, 12'b110000_110000);
`endif
    build_model(16'h20DF, 1);
    compare_wave("data_wave", 1920);
    check("data_done_at", first_done(1922), 1920);
    check("data_done_count", count_done(1922), 1);
    check("data_busy_cycles", count_busy(1922), 1920);
    repeat (4) @(posedge clk27);
    #1;

    // Data frame followed by one repeat frame
    repeat_hold = 1'b1;
    kick(16'h20DF);
    capture(3842, -1, 2500, -1);
    check("rpt_busy_boundary", bz[1920], 1'b1);
    check("rpt_lead", cap[1920], led_of(1'b1, 0));
    check("rpt_space", cap[2080], led_of(1'b0, 0));
    check("rpt_stop", cap[2120], led_of(1'b1, 0));
    check("rpt_gap", cap[2130], led_of(1'b0, 0));
    build_model(16'h20DF, 2);
    compare_wave("rpt_wave", 3840);
    check("rpt_done_at", first_done(3842), 3840);
    check("rpt_done_count", count_done(3842), 1);
    check("rpt_busy_cycles", count_busy(3842), 3840);
    repeat (4) @(posedge clk27);
    #1;

    // One-cycle reset mid-frame
    kick(16'h20DF);
    capture(800, -1, -1, 700);
    check("mrst_led", cap[701], led_of(1'b0, 0));
    check("mrst_busy", bz[701], 1'b0);
    check("mrst_done", dn[701], 1'b0);
    check("mrst_no_done", count_done(800), 0);
    check("mrst_led_after", cap[799], led_of(1'b0, 0));

    // Fresh frame after the reset
    kick(16'h1C3E);
    capture(1922, -1, -1, -1);
    build_model(16'h1C3E, 1);
    compare_wave("fresh_wave", 1920);
    check("fresh_done_at", first_done(1922), 1920);
    check("fresh_done_count", count_done(1922), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
